// File: rtl/axis_burst_framer.sv
// Store-and-forward burst framer: buffers whole tlast bursts (dropping any that cannot fit) and replays
// each committed burst behind a one-beat header; header valid 2 cycles after tlast; slave never stalls.
module axis_burst_framer #(
    parameter int  CHANNEL_WIDTH = 64,
    parameter int  BUF_DEPTH     = 64,
    parameter int  MAX_BURST     = 32,
    parameter int  DESC_DEPTH    = 4,
    localparam int DATA_WIDTH    = 4 * CHANNEL_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [15:0]           stat_drops,
    output logic [31:0]           stat_frames
);
    localparam int AW  = $clog2(BUF_DEPTH);
    localparam int DAW = $clog2(DESC_DEPTH);
    localparam int LW  = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISCARD} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA, R_GAP} rstate_t;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]         dstart [DESC_DEPTH];
    logic [LW-1:0]         dlen   [DESC_DEPTH];
    logic [63:0]           dts    [DESC_DEPTH];

    logic [63:0]           ts_q;
    wstate_t               ws_q, ws_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, start_q, start_d;
    logic [LW-1:0]         cnt_q, cnt_d;
    logic [63:0]           bts_q, bts_d;
    logic [AW:0]           used_q, used_d, rewind, freed;
    logic                  commit_q, commit_d;
    logic [AW-1:0]         c_start_q, c_start_d;
    logic [LW-1:0]         c_len_q, c_len_d;
    logic [63:0]           c_ts_q, c_ts_d;
    logic [15:0]           drops_q, drops_d;
    logic [DAW-1:0]        dwp_q, drp_q;
    logic [DAW:0]          dcnt_q;
    logic [DAW+1:0]        desc_occ;
    logic                  wr_en, drop, buf_full, desc_full;

    rstate_t               rs_q, rs_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         beat_q, beat_d, cur_len;
    logic [31:0]           seq_q, seq_d, frames_q, frames_d;
    logic                  mv_q, mv_d, ml_q, ml_d, pop, hs;
    logic [DATA_WIDTH-1:0] md_q, md_d, hdr;

    assign s_axis_tready = ~rst;
    assign m_axis_tvalid = mv_q;
    assign m_axis_tdata  = md_q;
    assign m_axis_tlast  = ml_q;
    assign stat_drops    = drops_q;
    assign stat_frames   = frames_q;

    // A commit still waiting in the pipeline register already owns a descriptor slot.
    assign desc_occ  = {1'b0, dcnt_q} + {{(DAW+1){1'b0}}, commit_q};
    assign desc_full = desc_occ >= (DAW+2)'(DESC_DEPTH);
    assign buf_full  = used_q == (AW+1)'(BUF_DEPTH);
    assign cur_len   = dlen[drp_q];
    assign hs        = mv_q & m_axis_tready;

    always_comb begin
        ws_d      = ws_q;
        wr_ptr_d  = wr_ptr_q;
        start_d   = start_q;
        cnt_d     = cnt_q;
        bts_d     = bts_q;
        commit_d  = 1'b0;
        c_start_d = c_start_q;
        c_len_d   = c_len_q;
        c_ts_d    = c_ts_q;
        drops_d   = drops_q;
        wr_en     = 1'b0;
        drop      = 1'b0;
        rewind    = '0;
        if (s_axis_tvalid) begin
            case (ws_q)
                W_IDLE: begin
                    if (buf_full || desc_full) begin
                        drop = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        start_d  = wr_ptr_q;
                        cnt_d    = LW'(1);
                        bts_d    = ts_q;
                        if (s_axis_tlast) begin
                            commit_d  = 1'b1;
                            c_start_d = wr_ptr_q;
                            c_len_d   = LW'(1);
                            c_ts_d    = ts_q;
                        end else begin
                            ws_d = W_FILL;
                        end
                    end
                end
                W_FILL: begin
                    if (buf_full || cnt_q == LW'(MAX_BURST)) begin
                        drop     = 1'b1;
                        wr_ptr_d = start_q;
                        rewind   = (AW+1)'(cnt_q);
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        cnt_d    = cnt_q + LW'(1);
                        if (s_axis_tlast) begin
                            commit_d  = 1'b1;
                            c_start_d = start_q;
                            c_len_d   = cnt_q + LW'(1);
                            c_ts_d    = bts_q;
                            ws_d      = W_IDLE;
                        end
                    end
                end
                default: begin
                    if (s_axis_tlast) ws_d = W_IDLE;
                end
            endcase
            if (drop) begin
                if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
                ws_d = s_axis_tlast ? W_IDLE : W_DISCARD;
            end
        end
    end

    always_comb begin
        hdr            = '0;
        hdr[31:0]      = 32'h5A5A_0001;
        hdr[63:32]     = seq_q;
        hdr[127:64]    = dts[drp_q];
        hdr[143:128]   = 16'(cur_len);
        hdr[159:144]   = drops_q;
    end

    always_comb begin
        rs_d     = rs_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        seq_d    = seq_q;
        frames_d = frames_q;
        mv_d     = mv_q;
        md_d     = md_q;
        ml_d     = ml_q;
        pop      = 1'b0;
        case (rs_q)
            R_HDR: begin
                if (hs) begin
                    md_d     = mem[rd_ptr_q];
                    ml_d     = cur_len == LW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    beat_d   = LW'(1);
                    rs_d     = R_DATA;
                end
            end
            R_DATA: begin
                if (hs) begin
                    if (ml_q) begin
                        pop      = 1'b1;
                        mv_d     = 1'b0;
                        ml_d     = 1'b0;
                        seq_d    = seq_q + 32'd1;
                        frames_d = frames_q + 32'd1;
                        rs_d     = R_GAP;
                    end else begin
                        md_d     = mem[rd_ptr_q];
                        ml_d     = (beat_q + LW'(1)) == cur_len;
                        beat_d   = beat_q + LW'(1);
                        rd_ptr_d = rd_ptr_q + AW'(1);
                    end
                end
            end
            default: begin
                // The gap cycle itself may load the next header, so frames are separated by exactly one idle beat.
                rs_d = R_IDLE;
                if (dcnt_q != '0) begin
                    mv_d     = 1'b1;
                    md_d     = hdr;
                    ml_d     = 1'b0;
                    rd_ptr_d = dstart[drp_q];
                    rs_d     = R_HDR;
                end
            end
        endcase
    end

    assign freed  = pop ? (AW+1)'(cur_len) : '0;
    assign used_d = used_q + (AW+1)'(wr_en) - rewind - freed;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= s_axis_tdata;
        if (commit_q) begin
            dstart[dwp_q] <= c_start_q;
            dlen[dwp_q]   <= c_len_q;
            dts[dwp_q]    <= c_ts_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q      <= '0;
            ws_q      <= W_IDLE;
            wr_ptr_q  <= '0;
            start_q   <= '0;
            cnt_q     <= '0;
            bts_q     <= '0;
            used_q    <= '0;
            commit_q  <= 1'b0;
            c_start_q <= '0;
            c_len_q   <= '0;
            c_ts_q    <= '0;
            drops_q   <= '0;
            dwp_q     <= '0;
            drp_q     <= '0;
            dcnt_q    <= '0;
            rs_q      <= R_IDLE;
            rd_ptr_q  <= '0;
            beat_q    <= '0;
            seq_q     <= '0;
            frames_q  <= '0;
            mv_q      <= 1'b0;
            md_q      <= '0;
            ml_q      <= 1'b0;
        end else begin
            ts_q      <= ts_q + 64'd1;
            ws_q      <= ws_d;
            wr_ptr_q  <= wr_ptr_d;
            start_q   <= start_d;
            cnt_q     <= cnt_d;
            bts_q     <= bts_d;
            used_q    <= used_d;
            commit_q  <= commit_d;
            c_start_q <= c_start_d;
            c_len_q   <= c_len_d;
            c_ts_q    <= c_ts_d;
            drops_q   <= drops_d;
            dwp_q     <= dwp_q + DAW'(commit_q);
            drp_q     <= drp_q + DAW'(pop);
            dcnt_q    <= dcnt_q + (DAW+1)'(commit_q) - (DAW+1)'(pop);
            rs_q      <= rs_d;
            rd_ptr_q  <= rd_ptr_d;
            beat_q    <= beat_d;
            seq_q     <= seq_d;
            frames_q  <= frames_d;
            mv_q      <= mv_d;
            md_q      <= md_d;
            ml_q      <= ml_d;
        end
    end
endmodule

// File: tb/tb_axis_burst_framer.sv
// Directed bench for axis_burst_framer: hand-built expected frames compared against captured master beats.
`timescale 1ns/1ps
module tb_axis_burst_framer;
    localparam int DW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast  = 1'b0;
    logic [DW-1:0] s_axis_tdata  = '0;
    logic          m_axis_tready = 1'b0;
    logic          s_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [15:0]   stat_drops;
    logic [31:0]   stat_frames;

    int errors = 0;
    int checks = 0;
    int cyc;

    logic [DW-1:0] cap_dat[$];
    logic          cap_last[$];
    int            cap_cyc[$];
    logic [DW-1:0] exp_dat[$];
    logic          exp_last[$];

    axis_burst_framer dut (
        .clk(clk), .rst(rst),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .stat_drops(stat_drops), .stat_frames(stat_frames)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            cap_dat.push_back(m_axis_tdata);
            cap_last.push_back(m_axis_tlast);
            cap_cyc.push_back(cyc);
        end
    end

    function automatic logic [DW-1:0] beat(input int tag, input int idx);
        return {4{tag, idx}};
    endfunction

    function automatic logic [DW-1:0] hdr(input int seq, input int ts, input int len, input int drops);
        logic [DW-1:0] h;
        h          = '0;
        h[31:0]    = 32'h5A5A_0001;
        h[63:32]   = seq;
        h[127:64]  = {32'd0, ts};
        h[143:128] = len[15:0];
        h[159:144] = drops[15:0];
        return h;
    endfunction

    task automatic exp_frame(input int seq, input int ts, input int len, input int drops, input int tag);
        exp_dat.push_back(hdr(seq, ts, len, drops));
        exp_last.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            exp_dat.push_back(beat(tag, i));
            exp_last.push_back(i == len - 1);
        end
    endtask

    task automatic clear_q();
        cap_dat.delete(); cap_last.delete(); cap_cyc.delete();
        exp_dat.delete(); exp_last.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_q();
    endtask

    task automatic send_burst(input int tag, input int len, output int ts, output int end_cyc);
        ts = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (i == 0) ts = cyc;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beat(tag, i);
            s_axis_tlast  = (i == len - 1);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        end_cyc = cyc;
    endtask

    task automatic wait_caps(input int n, input int budget, output bit ok);
        int c = 0;
        while (cap_dat.size() < n && c < budget) begin
            @(posedge clk);
            c++;
        end
        ok = cap_dat.size() >= n;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b want 0", s_axis_tready); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        checks++; if (stat_drops !== 16'd0) begin errors++; $display("FAIL reset_drops: got %0d want 0", stat_drops); end
        checks++; if (stat_frames !== 32'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", stat_frames); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL run_tready: got %b want 1", s_axis_tready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL idle_tvalid: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_single_32();
        int ts, ec; bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        send_burst(1, 32, ts, ec);
        exp_frame(0, ts, 32, 0, 1);
        wait_caps(33, 100, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d beats want 33", cap_dat.size()); end
        repeat (10) @(posedge clk);
        checks++; if (cap_dat.size() != 33) begin errors++; $display("FAIL single_count: got %0d want 33", cap_dat.size()); end
        for (int i = 0; i < 33 && i < cap_dat.size(); i++) begin
            checks++;
            if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL single_beat%0d: got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
            end
        end
        if (cap_dat.size() == 33) begin
            checks++; if (cap_cyc[0] !== ec + 2) begin errors++; $display("FAIL single_latency: got cycle %0d want %0d", cap_cyc[0], ec + 2); end
            checks++; if (cap_cyc[32] - cap_cyc[0] !== 32) begin errors++; $display("FAIL single_bubbles: got span %0d want 32", cap_cyc[32] - cap_cyc[0]); end
        end
        checks++; if (stat_frames !== 32'd1) begin errors++; $display("FAIL single_frames: got %0d want 1", stat_frames); end
    endtask

    task automatic test_one_beat();
        int ts1, ec1, ts2, ec2; bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        send_burst(2, 1, ts1, ec1);
        send_burst(3, 1, ts2, ec2);
        exp_frame(0, ts1, 1, 0, 2);
        exp_frame(1, ts2, 1, 0, 3);
        wait_caps(4, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL onebeat_timeout: got %0d beats want 4", cap_dat.size()); end
        repeat (10) @(posedge clk);
        checks++; if (cap_dat.size() != 4) begin errors++; $display("FAIL onebeat_count: got %0d want 4", cap_dat.size()); end
        for (int i = 0; i < 4 && i < cap_dat.size(); i++) begin
            checks++;
            if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL onebeat_beat%0d: got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
            end
        end
        if (cap_dat.size() == 4) begin
            checks++; if (cap_cyc[0] !== ec1 + 2) begin errors++; $display("FAIL onebeat_latency: got cycle %0d want %0d", cap_cyc[0], ec1 + 2); end
            checks++; if (cap_cyc[2] - cap_cyc[1] !== 2) begin errors++; $display("FAIL onebeat_gap: got spacing %0d want 2", cap_cyc[2] - cap_cyc[1]); end
        end
    endtask

    task automatic test_drop_long();
        int ts_a, ec_a, ts_b, ec_b; bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        send_burst(4, 33, ts_a, ec_a);
        checks++; if (stat_drops !== 16'd1) begin errors++; $display("FAIL long_drops: got %0d want 1", stat_drops); end
        send_burst(5, 8, ts_b, ec_b);
        exp_frame(0, ts_b, 8, 1, 5);
        wait_caps(9, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL long_timeout: got %0d beats want 9", cap_dat.size()); end
        repeat (40) @(posedge clk);
        checks++; if (cap_dat.size() != 9) begin errors++; $display("FAIL long_count: got %0d want 9", cap_dat.size()); end
        for (int i = 0; i < 9 && i < cap_dat.size(); i++) begin
            checks++;
            if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL long_beat%0d: got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
            end
        end
        checks++; if (stat_frames !== 32'd1) begin errors++; $display("FAIL long_frames: got %0d want 1", stat_frames); end
    endtask

    task automatic test_backpressure();
        int ts_a, ec_a, ts_b, ec_b; bit ok;
        bit stalled = 1'b0, was_last = 1'b0, first_done = 1'b0;
        logic [DW-1:0] held = '0;
        logic held_last = 1'b0;
        do_reset();
        m_axis_tready = 1'b0;
        send_burst(6, 16, ts_a, ec_a);
        send_burst(7, 16, ts_b, ec_b);
        exp_frame(0, ts_a, 16, 0, 6);
        exp_frame(1, ts_b, 16, 0, 7);
        for (int c = 0; c < 200 && cap_dat.size() < 34; c++) begin
            @(posedge clk); #1 m_axis_tready = ~m_axis_tready;
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held || m_axis_tlast !== held_last) begin
                    errors++; $display("FAIL bp_stable: got %b/%h/%b want 1/%h/%b", m_axis_tvalid, m_axis_tdata, m_axis_tlast, held, held_last);
                end
            end
            if (was_last) begin
                checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_gap_valid: got %b want 0", m_axis_tvalid); end
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            held      = m_axis_tdata;
            held_last = m_axis_tlast;
            was_last  = m_axis_tvalid && m_axis_tready && m_axis_tlast && !first_done;
            if (was_last) first_done = 1'b1;
        end
        m_axis_tready = 1'b1;
        wait_caps(34, 20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d beats want 34", cap_dat.size()); end
        repeat (10) @(posedge clk);
        checks++; if (cap_dat.size() != 34) begin errors++; $display("FAIL bp_count: got %0d want 34", cap_dat.size()); end
        for (int i = 0; i < 34 && i < cap_dat.size(); i++) begin
            checks++;
            if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
            end
        end
        if (cap_dat.size() == 34) begin
            checks++; if (cap_cyc[17] - cap_cyc[16] !== 2) begin errors++; $display("FAIL bp_gap: got spacing %0d want 2", cap_cyc[17] - cap_cyc[16]); end
        end
        checks++; if (stat_frames !== 32'd2) begin errors++; $display("FAIL bp_frames: got %0d want 2", stat_frames); end
    endtask

    task automatic test_overflow();
        int ts_a, ec_a, ts_b, ec_b, ts_c, ec_c; bit ok;
        do_reset();
        m_axis_tready = 1'b0;
        send_burst(8, 32, ts_a, ec_a);
        send_burst(9, 32, ts_b, ec_b);
        send_burst(10, 32, ts_c, ec_c);
        checks++; if (stat_drops !== 16'd1) begin errors++; $display("FAIL ovf_drops: got %0d want 1", stat_drops); end
        checks++; if (cap_dat.size() != 0) begin errors++; $display("FAIL ovf_stalled: got %0d beats want 0", cap_dat.size()); end
        exp_frame(0, ts_a, 32, 0, 8);
        exp_frame(1, ts_b, 32, 1, 9);
        m_axis_tready = 1'b1;
        wait_caps(66, 300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got %0d beats want 66", cap_dat.size()); end
        repeat (40) @(posedge clk);
        checks++; if (cap_dat.size() != 66) begin errors++; $display("FAIL ovf_count: got %0d want 66", cap_dat.size()); end
        for (int i = 0; i < 66 && i < cap_dat.size(); i++) begin
            checks++;
            if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL ovf_beat%0d: got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
            end
        end
        checks++; if (stat_frames !== 32'd2) begin errors++; $display("FAIL ovf_frames: got %0d want 2", stat_frames); end
    endtask

    task automatic test_reset_mid_frame();
        int ts_a, ec_a, ts_b, ec_b; bit ok;
        do_reset();
        m_axis_tready = 1'b1;
        send_burst(11, 16, ts_a, ec_a);
        wait_caps(5, 60, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: got %0d beats want 5", cap_dat.size()); end
        #1 rst = 1'b1;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_async_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL mid_tready: got %b want 0", s_axis_tready); end
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        checks++; if (cap_dat.size() != 5) begin errors++; $display("FAIL mid_leftover: got %0d beats want 5", cap_dat.size()); end
        checks++; if (stat_frames !== 32'd0) begin errors++; $display("FAIL mid_frames: got %0d want 0", stat_frames); end
        clear_q();
        send_burst(12, 4, ts_b, ec_b);
        exp_frame(0, ts_b, 4, 0, 12);
        wait_caps(5, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL post_timeout: got %0d beats want 5", cap_dat.size()); end
        repeat (10) @(posedge clk);
        checks++; if (cap_dat.size() != 5) begin errors++; $display("FAIL post_count: got %0d want 5", cap_dat.size()); end
        for (int i = 0; i < 5 && i < cap_dat.size(); i++) begin
            checks++;
            if (cap_dat[i] !== exp_dat[i] || cap_last[i] !== exp_last[i]) begin
                errors++; $display("FAIL post_beat%0d: got %h/%b want %h/%b", i, cap_dat[i], cap_last[i], exp_dat[i], exp_last[i]);
            end
        end
        checks++; if (stat_frames !== 32'd1) begin errors++; $display("FAIL post_frames: got %0d want 1", stat_frames); end
    endtask

    initial begin
        test_reset();
        test_single_32();
        test_one_beat();
        test_drop_long();
        test_backpressure();
        test_overflow();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
